// File: rtl/traffic_light_pkg.sv
// Shared state encodings, default phase durations and the lamp decode used by
// the junction-arm traffic light controller.
package traffic_light_pkg;

  localparam logic [2:0] ST_GREEN     = 3'd0;
  localparam logic [2:0] ST_AMBER     = 3'd1;
  localparam logic [2:0] ST_RED       = 3'd2;
  localparam logic [2:0] ST_RED_AMBER = 3'd3;
  localparam logic [2:0] ST_FLASH     = 3'd4;

  localparam int DEF_CNT_W          = 8;
  localparam int DEF_GREEN_CYC      = 6;
  localparam int DEF_AMBER_CYC      = 2;
  localparam int DEF_RED_CYC        = 7;
  localparam int DEF_RED_AMBER_CYC  = 2;
  localparam int DEF_MIN_GREEN_CYC  = 3;
  localparam int DEF_FLASH_HALF_CYC = 4;

  // Lamp pattern {red, amber, green, walk}; unknown encodings show a safe red.
  function automatic logic [3:0] lamps_for_state(input logic [2:0] st);
    logic [3:0] lamps;
    case (st)
      ST_GREEN:     lamps = 4'b0010;
      ST_AMBER:     lamps = 4'b0100;
      ST_RED:       lamps = 4'b1001;
      ST_RED_AMBER: lamps = 4'b1100;
      ST_FLASH:     lamps = 4'b0100;
      default:      lamps = 4'b1000;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Up-counter with synchronous clear and a terminal compare against a runtime
// last-count value; times both traffic phases and the flash half-period.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] last_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == last_i);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Junction-arm traffic light sequencer with pedestrian request latching.
// Define TRAFFIC_LIGHT_FLASH_EN to add the maint_i flashing-amber mode.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int GREEN_CYC      = DEF_GREEN_CYC,
  parameter int AMBER_CYC      = DEF_AMBER_CYC,
  parameter int RED_CYC        = DEF_RED_CYC,
  parameter int RED_AMBER_CYC  = DEF_RED_AMBER_CYC,
  parameter int MIN_GREEN_CYC  = DEF_MIN_GREEN_CYC,
  parameter int FLASH_HALF_CYC = DEF_FLASH_HALF_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pedestrian_button_i,
`ifdef TRAFFIC_LIGHT_FLASH_EN
  input  logic maint_i,
`endif
  output logic red_o,
  output logic amber_o,
  output logic green_o,
  output logic walk_o,
  output logic ped_pending_o
);

  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST     = CNT_W'(AMBER_CYC - 1);
  localparam logic [CNT_W-1:0] RED_LAST       = CNT_W'(RED_CYC - 1);
  localparam logic [CNT_W-1:0] RED_AMBER_LAST = CNT_W'(RED_AMBER_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST       = CNT_W'(MIN_GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_HALF_CYC - 1);

  logic [2:0]       state_q, state_d, base_state_s;
  logic             ped_req_q, ped_req_d;
  logic [3:0]       lamps_q, lamps_d;
  logic [CNT_W-1:0] cnt_s, last_s;
  logic             done_s, clr_s, ped_hit_s;

  assign ped_hit_s = ped_req_q | pedestrian_button_i;

  // Terminal count for whichever phase is currently running.
  always_comb begin
    case (state_q)
      ST_GREEN:     last_s = GREEN_LAST;
      ST_AMBER:     last_s = AMBER_LAST;
      ST_RED:       last_s = RED_LAST;
      ST_RED_AMBER: last_s = RED_AMBER_LAST;
      ST_FLASH:     last_s = FLASH_LAST;
      default:      last_s = '0;
    endcase
  end

  // Normal phase sequencing; a pedestrian can only cut GREEN short.
  always_comb begin
    case (state_q)
      ST_GREEN: begin
        if (done_s || (ped_hit_s && (cnt_s >= MIN_LAST))) begin
          base_state_s = ST_AMBER;
        end else begin
          base_state_s = ST_GREEN;
        end
      end
      ST_AMBER:     base_state_s = done_s ? ST_RED : ST_AMBER;
      ST_RED:       base_state_s = done_s ? ST_RED_AMBER : ST_RED;
      ST_RED_AMBER: base_state_s = done_s ? ST_GREEN : ST_RED_AMBER;
      default:      base_state_s = ST_RED;
    endcase
  end

`ifdef TRAFFIC_LIGHT_FLASH_EN
  logic flash_amb_q, flash_amb_d, flash_wrap_s;

  assign state_d      = maint_i ? ST_FLASH : base_state_s;
  assign flash_wrap_s = (state_q == ST_FLASH) && (state_d == ST_FLASH) && done_s;
  assign clr_s        = (state_d != state_q) || flash_wrap_s;

  // Flashing amber starts lit on entry and toggles every half-period.
  always_comb begin
    if (state_d != ST_FLASH) begin
      flash_amb_d = 1'b1;
    end else if (state_q != ST_FLASH) begin
      flash_amb_d = 1'b1;
    end else if (done_s) begin
      flash_amb_d = ~flash_amb_q;
    end else begin
      flash_amb_d = flash_amb_q;
    end
  end

  // Flash amber phase register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flash_amb_q <= 1'b1;
    end else begin
      flash_amb_q <= flash_amb_d;
    end
  end
`else
  assign state_d = base_state_s;
  assign clr_s   = (state_d != state_q);
`endif

  // Pedestrian latch: serviced on entry to RED, ignored while walk is shown.
  always_comb begin
`ifdef TRAFFIC_LIGHT_FLASH_EN
    if ((state_q == ST_FLASH) || (state_d == ST_FLASH)) begin
      ped_req_d = 1'b0;
    end else
`endif
    if ((state_q == ST_AMBER) && (state_d == ST_RED)) begin
      ped_req_d = 1'b0;
    end else if (pedestrian_button_i && (state_q != ST_RED)) begin
      ped_req_d = 1'b1;
    end else begin
      ped_req_d = ped_req_q;
    end
  end

  // Lamps are registered from the next state so they track state_q exactly.
  always_comb begin
    lamps_d = lamps_for_state(state_d);
`ifdef TRAFFIC_LIGHT_FLASH_EN
    if (state_d == ST_FLASH) begin
      lamps_d = {1'b0, flash_amb_d, 2'b00};
    end else begin
      lamps_d = lamps_for_state(state_d);
    end
`endif
  end

  // State, pedestrian latch and lamp registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RED;
      ped_req_q <= 1'b0;
      lamps_q   <= 4'b1000;
    end else begin
      state_q   <= state_d;
      ped_req_q <= ped_req_d;
      lamps_q   <= lamps_d;
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_s),
    .last_i (last_s),
    .cnt_o  (cnt_s),
    .done_o (done_s)
  );

  assign red_o         = lamps_q[3];
  assign amber_o       = lamps_q[2];
  assign green_o       = lamps_q[1];
  assign walk_o        = lamps_q[0];
  assign ped_pending_o = ped_req_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed vector table, hand
// sequences for reset/sweep/flash corners, and randomized model comparison.
module tb_traffic_light_ctrl;

  logic clk_i = 1'b0;
  logic rst_i, btn, btn_s;
  logic red, amber, green, walk, pend;
  logic red_s, amber_s, green_s, walk_s, pend_s;
`ifdef TRAFFIC_LIGHT_FLASH_EN
  logic maint, maint_s;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  traffic_light_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .pedestrian_button_i(btn),
`ifdef TRAFFIC_LIGHT_FLASH_EN
    .maint_i(maint),
`endif
    .red_o(red), .amber_o(amber), .green_o(green), .walk_o(walk), .ped_pending_o(pend)
  );

  traffic_light_ctrl #(
    .CNT_W(2), .GREEN_CYC(1), .AMBER_CYC(2), .RED_CYC(4), .RED_AMBER_CYC(2), .MIN_GREEN_CYC(1)
  ) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .pedestrian_button_i(btn_s),
`ifdef TRAFFIC_LIGHT_FLASH_EN
    .maint_i(maint_s),
`endif
    .red_o(red_s), .amber_o(amber_s), .green_o(green_s), .walk_o(walk_s), .ped_pending_o(pend_s)
  );

  // Observation patterns {red, amber, green, walk, pending}
  localparam logic [4:0] R   = 5'b10000;
  localparam logic [4:0] RW  = 5'b10010;
  localparam logic [4:0] RA  = 5'b11000;
  localparam logic [4:0] G   = 5'b00100;
  localparam logic [4:0] A   = 5'b01000;
  localparam logic [4:0] P   = 5'b00001;
  localparam logic [4:0] OFF = 5'b00000;

  typedef struct { logic b; logic [4:0] exp; } vec_t;
  vec_t vecs[$];

  // Reference model: phase index 0=RED 1=RED_AMBER 2=GREEN 3=AMBER, time in completed cycles
  int dur [2][4];
  int min_g [2];
  int m_ph [2];
  int m_el [2];
  bit m_pend [2];
  bit m_fresh [2];

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (r a g w p) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs();
    return {red, amber, green, walk, pend};
  endfunction

  function automatic logic [4:0] obs_s();
    return {red_s, amber_s, green_s, walk_s, pend_s};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic add_seg(input int n, input logic b, input logic [4:0] e);
    for (int i = 0; i < n; i++) vecs.push_back('{b: b, exp: e});
  endtask

  task automatic model_reset(input int id);
    m_ph[id] = 0; m_el[id] = 0; m_pend[id] = 1'b0; m_fresh[id] = 1'b1;
  endtask

  task automatic model_step(input int id, input bit b);
    bit hit, leave;
    int done_cycles;
    hit = m_pend[id] | b;
    done_cycles = m_el[id] + 1;
    if (m_ph[id] == 3 && done_cycles == dur[id][3]) m_pend[id] = 1'b0;
    else if (b && m_ph[id] != 0) m_pend[id] = 1'b1;
    if (m_ph[id] == 2) leave = (done_cycles == dur[id][2]) || (hit && done_cycles >= min_g[id]);
    else leave = (done_cycles == dur[id][m_ph[id]]);
    if (leave) begin
      m_ph[id] = (m_ph[id] + 1) % 4;
      m_el[id] = 0;
    end else begin
      m_el[id] = done_cycles;
    end
    m_fresh[id] = 1'b0;
  endtask

  function automatic logic [4:0] model_out(input int id);
    logic [4:0] o;
    case (m_ph[id])
      0:       o = m_fresh[id] ? R : RW;
      1:       o = RA;
      2:       o = G;
      default: o = A;
    endcase
    return o | (m_pend[id] ? P : OFF);
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic wait_green();
    for (int i = 0; i < 40 && green !== 1'b1; i++) step();
    check("wait_green", {4'b0000, green}, 5'b00001);
  endtask

  initial begin
    dur[0] = '{7, 2, 6, 2}; min_g[0] = 3;
    dur[1] = '{4, 2, 1, 2}; min_g[1] = 1;
    rst_i = 1'b1; btn = 1'b0; btn_s = 1'b0;
`ifdef TRAFFIC_LIGHT_FLASH_EN
    maint = 1'b0; maint_s = 1'b0;
`endif

    // Two idle periods after reset, then the pedestrian scenarios
    add_seg(1, 1'b0, R);  add_seg(6, 1'b0, RW); add_seg(2, 1'b0, RA); add_seg(6, 1'b0, G); add_seg(2, 1'b0, A);
    add_seg(7, 1'b0, RW); add_seg(2, 1'b0, RA); add_seg(6, 1'b0, G);  add_seg(2, 1'b0, A);
    add_seg(7, 1'b0, RW); add_seg(2, 1'b0, RA);
    add_seg(1, 1'b1, G);  add_seg(2, 1'b0, G | P); add_seg(2, 1'b0, A | P); add_seg(7, 1'b0, RW); add_seg(2, 1'b0, RA);
    add_seg(4, 1'b0, G);  add_seg(1, 1'b1, G);  add_seg(2, 1'b1, A | P); add_seg(7, 1'b1, RW);
    add_seg(1, 1'b1, RA); add_seg(1, 1'b1, RA | P); add_seg(3, 1'b1, G | P); add_seg(2, 1'b1, A | P);
    add_seg(3, 1'b0, RW); add_seg(1, 1'b1, RW); add_seg(3, 1'b0, RW); add_seg(2, 1'b0, RA);
    add_seg(6, 1'b0, G);  add_seg(2, 1'b0, A);  add_seg(1, 1'b0, RW);

    repeat (2) step();
    check("reset_main", obs(), R);
    check("reset_sweep", obs_s(), R);
    rst_i = 1'b0;
    foreach (vecs[k]) begin
      check($sformatf("vec%0d", k), obs(), vecs[k].exp);
      btn = vecs[k].b;
      step();
    end
    btn = 1'b0;

    // Asynchronous reset at GREEN cnt=2, released mid-cycle
    wait_green();
    repeat (2) step();
    check("green_cnt2", obs(), G);
    #2 rst_i = 1'b1;
    #1 check("async_rst", obs(), R);
    #2 rst_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("post_rst_red%0d", k), obs(), (k == 0) ? R : RW);
      step();
    end
    check("post_rst_ra", obs(), RA);

    // Narrow counter sweep instance, idle button
    do_reset();
    for (int k = 0; k < 18; k++) begin
      int m;
      logic [4:0] e;
      m = k % 9;
      if (k == 0) e = R;
      else if (m <= 3) e = RW;
      else if (m <= 5) e = RA;
      else if (m == 6) e = G;
      else e = A;
      check($sformatf("sweep%0d", k), obs_s(), e);
      step();
    end

`ifdef TRAFFIC_LIGHT_FLASH_EN
    wait_green();
    repeat (2) step();
    maint = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("flash%0d", i), obs(), ((i % 8) < 4) ? A : OFF);
      step();
    end
    maint = 1'b0;
    step();
    for (int k = 0; k < 7; k++) begin
      check($sformatf("flash_exit_red%0d", k), obs(), RW);
      step();
    end
    check("flash_exit_ra", obs(), RA);
`endif

    // Randomized buttons on both instances against the reference model
    do_reset();
    model_reset(0);
    model_reset(1);
    for (int c = 0; c < 1500; c++) begin
      check("rand_main", obs(), model_out(0));
      check("rand_sweep", obs_s(), model_out(1));
      btn   = ($urandom_range(0, 5) == 0);
      btn_s = ($urandom_range(0, 3) == 0);
      @(posedge clk_i);
      model_step(0, btn);
      model_step(1, btn_s);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
